// File: rtl/gmii_arp_rx.sv
// rtl/gmii_arp_rx.sv - GMII receive parser that extracts ARP requests/replies addressed to this station.
// Optional FCS checking is compiled in with the ARP_RX_CRC_EN macro.
module gmii_arp_rx #(
    parameter logic [47:0] LOCAL_MAC = 48'h000A35010203,
    parameter logic [31:0] LOCAL_IP  = 32'hC0A8010A,
    parameter int          MAX_FRAME = 1518
) (
    input  logic        gmii_clk,
    input  logic        rst_n,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic        arp_valid,
    output logic [15:0] arp_opcode,
    output logic [47:0] arp_src_mac,
    output logic [31:0] arp_src_ip,
    output logic        frame_err
);

    localparam logic [10:0] MAX_CNT = 11'(MAX_FRAME);
    localparam logic [10:0] MIN_CNT = 11'd64;

    typedef enum logic [2:0] {IDLE, PREAMBLE, ETH_HDR, ARP_BODY, TAIL, DROP} state_t;

    state_t      state;
    logic [10:0] count;
    logic        bc_ok, uc_ok, err_flag;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [15:0] oper;
    logic [7:0]  mac_byte, ip_byte;
    logic [1:0]  ip_sel;
    logic        bc_next, uc_next, byte_bad, crc_ok;

`ifdef ARP_RX_CRC_EN
    logic [31:0] crc, crc_rev;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // The reflected register holds the good-frame residue in bit-reversed form.
    always_comb begin
        crc_rev = '0;
        for (int i = 0; i < 32; i++)
            crc_rev[i] = crc[31-i];
        crc_ok = (crc_rev == 32'hC704DD7B);
    end
`else
    assign crc_ok = 1'b1;
`endif

    always_comb begin
        mac_byte = 8'(LOCAL_MAC >> {3'd5 - count[2:0], 3'b000});
        ip_sel   = 2'(count - 11'd38);
        ip_byte  = 8'(LOCAL_IP >> {2'd3 - ip_sel, 3'b000});
        bc_next  = bc_ok & (gmii_rxd == 8'hFF);
        uc_next  = uc_ok & (gmii_rxd == mac_byte);
        byte_bad = 1'b0;
        if (state == ETH_HDR) begin
            if (count < 11'd6)        byte_bad = !(bc_next || uc_next);
            else if (count == 11'd12) byte_bad = (gmii_rxd != 8'h08);
            else if (count == 11'd13) byte_bad = (gmii_rxd != 8'h06);
        end else if (state == ARP_BODY) begin
            case (count)
                11'd14, 11'd17, 11'd20: byte_bad = (gmii_rxd != 8'h00);
                11'd15:  byte_bad = (gmii_rxd != 8'h01);
                11'd16:  byte_bad = (gmii_rxd != 8'h08);
                11'd18:  byte_bad = (gmii_rxd != 8'h06);
                11'd19:  byte_bad = (gmii_rxd != 8'h04);
                11'd21:  byte_bad = (gmii_rxd != 8'h01) && (gmii_rxd != 8'h02);
                11'd38, 11'd39, 11'd40, 11'd41: byte_bad = (gmii_rxd != ip_byte);
                default: byte_bad = 1'b0;
            endcase
        end
    end

    always_ff @(posedge gmii_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            bc_ok       <= 1'b0;
            uc_ok       <= 1'b0;
            err_flag    <= 1'b0;
            sha         <= '0;
            spa         <= '0;
            oper        <= '0;
            arp_valid   <= 1'b0;
            frame_err   <= 1'b0;
            arp_opcode  <= '0;
            arp_src_mac <= '0;
            arp_src_ip  <= '0;
`ifdef ARP_RX_CRC_EN
            crc         <= 32'hFFFFFFFF;
`endif
        end else begin
            arp_valid <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    err_flag <= 1'b0;
                    if (gmii_rx_dv)
                        state <= (gmii_rxd == 8'h55) ? PREAMBLE : DROP;
                end
                PREAMBLE: begin
                    if (!gmii_rx_dv) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end else if (gmii_rxd == 8'hD5) begin
                        state <= ETH_HDR;
                        count <= '0;
                        bc_ok <= 1'b1;
                        uc_ok <= 1'b1;
`ifdef ARP_RX_CRC_EN
                        crc   <= 32'hFFFFFFFF;
`endif
                    end else if (gmii_rxd != 8'h55) begin
                        state <= DROP;
                    end
                end
                ETH_HDR, ARP_BODY, TAIL: begin
                    if (!gmii_rx_dv) begin
                        state <= IDLE;
                        if (state == TAIL && count >= MIN_CNT && count <= MAX_CNT && crc_ok) begin
                            arp_valid   <= 1'b1;
                            arp_opcode  <= oper;
                            arp_src_mac <= sha;
                            arp_src_ip  <= spa;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else if (gmii_rx_er) begin
                        state    <= DROP;
                        err_flag <= 1'b1;
                    end else if (byte_bad) begin
                        state <= DROP;
                    end else begin
                        if (count != 11'h7FF)
                            count <= count + 11'd1;
`ifdef ARP_RX_CRC_EN
                        crc <= crc_byte(crc, gmii_rxd);
`endif
                        if (count < 11'd6) begin
                            bc_ok <= bc_next;
                            uc_ok <= uc_next;
                        end
                        if (count == 11'd20) oper[15:8] <= gmii_rxd;
                        if (count == 11'd21) oper[7:0]  <= gmii_rxd;
                        if (count >= 11'd22 && count <= 11'd27) sha <= {sha[39:0], gmii_rxd};
                        if (count >= 11'd28 && count <= 11'd31) spa <= {spa[23:0], gmii_rxd};
                        if (state == ETH_HDR && count == 11'd13)  state <= ARP_BODY;
                        if (state == ARP_BODY && count == 11'd41) state <= TAIL;
                    end
                end
                DROP: begin
                    if (!gmii_rx_dv) begin
                        state     <= IDLE;
                        frame_err <= err_flag;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_arp_rx.sv
// tb/tb_gmii_arp_rx.sv - directed self-checking bench for gmii_arp_rx.
module tb_gmii_arp_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rxd = 8'h00;
    logic        dv = 1'b0;
    logic        er = 1'b0;
    logic        arp_valid, frame_err;
    logic [15:0] arp_opcode;
    logic [47:0] arp_src_mac;
    logic [31:0] arp_src_ip;

    int checks = 0;
    int errors = 0;
    int v_cnt = 0;
    int e_cnt = 0;
    logic [47:0] mac_hist[$];
    logic [7:0]  frm[$];

    localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;
    localparam logic [47:0] LMAC  = 48'h000A35010203;
    localparam logic [31:0] LIP   = 32'hC0A8010A;

    gmii_arp_rx dut (
        .gmii_clk(clk), .rst_n(rst_n), .gmii_rxd(rxd), .gmii_rx_dv(dv), .gmii_rx_er(er),
        .arp_valid(arp_valid), .arp_opcode(arp_opcode), .arp_src_mac(arp_src_mac),
        .arp_src_ip(arp_src_ip), .frame_err(frame_err)
    );

    always #4 clk = ~clk;

    always @(negedge clk) begin
        if (arp_valid) begin
            v_cnt++;
            mac_hist.push_back(arp_src_mac);
        end
        if (frame_err) e_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, frm[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build(input logic [47:0] dst, input logic [15:0] op, input logic [47:0] sha,
                         input logic [31:0] spa, input logic [31:0] tpa, input int pad);
        logic [31:0] f;
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(sha[47-8*i -: 8]);
        frm.push_back(8'h08); frm.push_back(8'h06);
        frm.push_back(8'h00); frm.push_back(8'h01); frm.push_back(8'h08); frm.push_back(8'h00);
        frm.push_back(8'h06); frm.push_back(8'h04);
        frm.push_back(op[15:8]); frm.push_back(op[7:0]);
        for (int i = 0; i < 6; i++) frm.push_back(sha[47-8*i -: 8]);
        for (int i = 0; i < 4; i++) frm.push_back(spa[31-8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(8'h00);
        for (int i = 0; i < 4; i++) frm.push_back(tpa[31-8*i -: 8]);
        for (int i = 0; i < pad; i++) frm.push_back(8'h00);
        f = fcs_of(frm.size());
        for (int i = 0; i < 4; i++) frm.push_back(f[8*i +: 8]);
    endtask

    // Preamble + SFD, then the first n bytes of frm; rx_er raised on byte er_at.
    task automatic send(input int n, input int er_at);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); dv = 1'b1; er = 1'b0; rxd = (i == 7) ? 8'hD5 : 8'h55;
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk); rxd = frm[i]; er = (i == er_at);
        end
        @(negedge clk); dv = 1'b0; rxd = 8'h00; er = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        #1;
    endtask

    initial begin
        int v0, e0, h0;
        repeat (3) @(negedge clk);
        check("reset_valid", arp_valid, 0);
        check("reset_err", frame_err, 0);
        check("reset_mac", arp_src_mac, 0);
        check("reset_opcode", arp_opcode, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Broadcast request with exact latency check
        build(BCAST, 16'h0001, 48'h021122334455, 32'hC0A80164, LIP, 18);
        v0 = v_cnt; e0 = e_cnt;
        send(frm.size(), -1);
        check("bc_latency_early", arp_valid, 0);
        @(negedge clk);
        check("bc_valid", arp_valid, 1);
        check("bc_opcode", arp_opcode, 16'h0001);
        check("bc_ip", arp_src_ip, 32'hC0A80164);
        check("bc_mac", arp_src_mac, 48'h021122334455);
        @(negedge clk);
        check("bc_one_cycle", arp_valid, 0);
        settle();
        check("bc_count", v_cnt - v0, 1);
        check("bc_no_err", e_cnt - e0, 0);

        // Wrong target IP: silent drop
        build(BCAST, 16'h0001, 48'h021122334455, 32'hC0A80164, 32'hC0A8010B, 18);
        v0 = v_cnt; e0 = e_cnt;
        send(frm.size(), -1);
        settle();
        check("tpa_no_valid", v_cnt - v0, 0);
        check("tpa_no_err", e_cnt - e0, 0);

        // Unicast reply
        build(LMAC, 16'h0002, 48'h026677889900, 32'hC0A80165, LIP, 18);
        v0 = v_cnt;
        send(frm.size(), -1);
        settle();
        check("uc_count", v_cnt - v0, 1);
        check("uc_opcode", arp_opcode, 16'h0002);
        check("uc_ip", arp_src_ip, 32'hC0A80165);

        // rx_er at byte 20
        build(BCAST, 16'h0001, 48'h02DEADBEEF01, 32'hC0A80199, LIP, 18);
        v0 = v_cnt; e0 = e_cnt;
        send(frm.size(), 20);
        @(negedge clk);
        check("er_pulse", frame_err, 1);
        settle();
        check("er_err_count", e_cnt - e0, 1);
        check("er_no_valid", v_cnt - v0, 0);
        check("er_hold_ip", arp_src_ip, 32'hC0A80165);
        check("er_hold_mac", arp_src_mac, 48'h026677889900);

        // Truncated after 30 bytes, then a good frame
        e0 = e_cnt; v0 = v_cnt;
        send(30, -1);
        settle();
        check("trunc_err", e_cnt - e0, 1);
        check("trunc_no_valid", v_cnt - v0, 0);
        build(BCAST, 16'h0001, 48'h020000000070, 32'hC0A80170, LIP, 18);
        send(frm.size(), -1);
        settle();
        check("post_trunc_valid", v_cnt - v0, 1);
        check("post_trunc_ip", arp_src_ip, 32'hC0A80170);

        // Corrupted last FCS byte
        build(BCAST, 16'h0001, 48'h020000000071, 32'hC0A80171, LIP, 18);
        frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h01;
        v0 = v_cnt; e0 = e_cnt;
        send(frm.size(), -1);
        settle();
`ifdef ARP_RX_CRC_EN
        check("badfcs_err", e_cnt - e0, 1);
        check("badfcs_valid", v_cnt - v0, 0);
`else
        check("badfcs_err", e_cnt - e0, 0);
        check("badfcs_valid", v_cnt - v0, 1);
`endif

        // Back-to-back with one idle cycle
        v0 = v_cnt; h0 = mac_hist.size();
        build(BCAST, 16'h0001, 48'h02AAAAAAAAAA, 32'hC0A80180, LIP, 18);
        send(frm.size(), -1);
        build(BCAST, 16'h0001, 48'h02BBBBBBBBBB, 32'hC0A80181, LIP, 18);
        send(frm.size(), -1);
        settle();
        check("b2b_count", v_cnt - v0, 2);
        if (mac_hist.size() >= h0 + 2) begin
            check("b2b_mac1", mac_hist[h0], 48'h02AAAAAAAAAA);
            check("b2b_mac2", mac_hist[h0+1], 48'h02BBBBBBBBBB);
        end
        check("b2b_ip", arp_src_ip, 32'hC0A80181);

        // Length boundaries: 46 (runt), 1518 (max), 1519 (oversize)
        e0 = e_cnt; v0 = v_cnt;
        build(BCAST, 16'h0001, 48'h020000000046, 32'hC0A80146, LIP, 0);
        send(frm.size(), -1);
        settle();
        check("runt_err", e_cnt - e0, 1);
        check("runt_no_valid", v_cnt - v0, 0);
        e0 = e_cnt; v0 = v_cnt;
        build(BCAST, 16'h0001, 48'h020000001518, 32'hC0A80118, LIP, 1472);
        send(frm.size(), -1);
        settle();
        check("max_valid", v_cnt - v0, 1);
        check("max_no_err", e_cnt - e0, 0);
        e0 = e_cnt; v0 = v_cnt;
        build(BCAST, 16'h0001, 48'h020000001519, 32'hC0A80119, LIP, 1473);
        send(frm.size(), -1);
        settle();
        check("over_err", e_cnt - e0, 1);
        check("over_no_valid", v_cnt - v0, 0);

        // Foreign unicast destination: silent drop
        e0 = e_cnt; v0 = v_cnt;
        build(48'h000A35010204, 16'h0001, 48'h020000000099, 32'hC0A80199, LIP, 18);
        send(frm.size(), -1);
        settle();
        check("foreign_no_valid", v_cnt - v0, 0);
        check("foreign_no_err", e_cnt - e0, 0);

        // Reset mid-frame, then a good frame
        e0 = e_cnt; v0 = v_cnt;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); dv = 1'b1; rxd = (i == 7) ? 8'hD5 : 8'h55;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); rxd = frm[i];
        end
        @(negedge clk); rst_n = 1'b0; dv = 1'b0; rxd = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        settle();
        check("rst_no_err", e_cnt - e0, 0);
        check("rst_no_valid", v_cnt - v0, 0);
        check("rst_clears_ip", arp_src_ip, 0);
        build(BCAST, 16'h0002, 48'h02CCCCCCCCCC, 32'hC0A801CC, LIP, 18);
        send(frm.size(), -1);
        settle();
        check("post_rst_valid", v_cnt - v0, 1);
        check("post_rst_opcode", arp_opcode, 16'h0002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
